// File: rtl/oam_dma_if.sv
// ---------------------------------------------------------------------------
// oam_dma_if
//
// Signal bundle between the sprite-DMA engine and its surroundings:
// the CPU register decode, the CPU-side RAM port and the PPU OAM write port.
//
//   start, page, oam_start : $4014 write pulse, source page and OAMADDR
//   mem_addr, mem_cs_n,    : RAM address and controls (DMA is bus master
//   mem_rw_n, mem_data       while busy); mem_data is the resolved read bus
//   oam_addr, oam_wdata,   : OAM write port
//   oam_we
//   busy, cpu_rdy, done    : status / CPU halt / end-of-transfer pulse
//
// master : the DMA engine.
// slave  : the environment (CPU decode, RAM, OAM).
// ---------------------------------------------------------------------------
interface oam_dma_if;
    logic        start;
    logic [7:0]  page;
    logic [7:0]  oam_start;
    logic [15:0] mem_addr;
    logic        mem_cs_n;
    logic        mem_rw_n;
    logic [7:0]  mem_data;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_wdata;
    logic        oam_we;
    logic        busy;
    logic        cpu_rdy;
    logic        done;

    modport master (
        input  start, page, oam_start, mem_data,
        output mem_addr, mem_cs_n, mem_rw_n,
        output oam_addr, oam_wdata, oam_we,
        output busy, cpu_rdy, done
    );

    modport slave (
        output start, page, oam_start, mem_data,
        input  mem_addr, mem_cs_n, mem_rw_n,
        input  oam_addr, oam_wdata, oam_we,
        input  busy, cpu_rdy, done
    );
endinterface

// File: rtl/oam_dma.sv
// ---------------------------------------------------------------------------
// oam_dma
//
// Sprite-DMA engine. A start pulse copies one page (PAGE_BYTES bytes) from
// the CPU RAM at {page, idx} into OAM at oam_start + idx (wrapping in OAM).
// Each byte takes two cycles: RD_ADDR presents the address to the
// registered-read RAM, RD_DATA sees the data and registers the OAM write,
// which then completes during the next byte's RD_ADDR cycle.
//
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : oam_dma_if.master (start/page/oam_start in, RAM controls out,
//           mem_data in, OAM write port out, busy/cpu_rdy/done out)
// ---------------------------------------------------------------------------
module oam_dma #(
    parameter int PAGE_BYTES = 256
) (
    input  logic      clk,
    input  logic      rst_n,
    oam_dma_if.master bus
);

    localparam logic [7:0] LAST_IDX = 8'(PAGE_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_RD_ADDR,
        S_RD_DATA,
        S_LAST
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  pg_q, pg_d;
    logic [7:0]  oa_q, oa_d;
    logic [7:0]  idx_q, idx_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic        mem_cs_n_q, mem_cs_n_d;
    logic        oam_we_q, oam_we_d;
    logic [7:0]  oam_addr_q, oam_addr_d;
    logic [7:0]  oam_wdata_q, oam_wdata_d;
    logic        done_q, done_d;
    logic        reading;

    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned; a missing default here would infer a latch.
    always_comb begin
        state_d     = state_q;
        pg_d        = pg_q;
        oa_d        = oa_q;
        idx_d       = idx_q;
        oam_we_d    = 1'b0;
        oam_addr_d  = oam_addr_q;
        oam_wdata_d = oam_wdata_q;
        done_d      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    pg_d    = bus.page;
                    oa_d    = bus.oam_start;
                    idx_d   = 8'd0;
                    state_d = S_HALT;
                end
            end
            S_HALT:    state_d = S_RD_ADDR;
            S_RD_ADDR: state_d = S_RD_DATA;
            S_RD_DATA: begin
                oam_we_d    = 1'b1;
                oam_addr_d  = oa_q + idx_q;   // wraps inside OAM only
                oam_wdata_d = bus.mem_data;
                if (idx_q == LAST_IDX) begin
                    state_d = S_LAST;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = S_RD_ADDR;
                end
            end
            S_LAST: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // RAM controls are registered from the next state so they line up
        // with the state they belong to and never see an input directly.
        reading    = (state_d == S_RD_ADDR) || (state_d == S_RD_DATA);
        mem_cs_n_d = !reading;
        mem_addr_d = reading ? {pg_d, idx_d} : 16'h0000;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pg_q        <= 8'h00;
            oa_q        <= 8'h00;
            idx_q       <= 8'h00;
            mem_addr_q  <= 16'h0000;
            mem_cs_n_q  <= 1'b1;
            oam_we_q    <= 1'b0;
            oam_addr_q  <= 8'h00;
            oam_wdata_q <= 8'h00;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pg_q        <= pg_d;
            oa_q        <= oa_d;
            idx_q       <= idx_d;
            mem_addr_q  <= mem_addr_d;
            mem_cs_n_q  <= mem_cs_n_d;
            oam_we_q    <= oam_we_d;
            oam_addr_q  <= oam_addr_d;
            oam_wdata_q <= oam_wdata_d;
            done_q      <= done_d;
        end
    end

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_cs_n  = mem_cs_n_q;
    assign bus.mem_rw_n  = 1'b1;          // read-only master
    assign bus.oam_addr  = oam_addr_q;
    assign bus.oam_wdata = oam_wdata_q;
    assign bus.oam_we    = oam_we_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.cpu_rdy   = (state_q == S_IDLE);
    assign bus.done      = done_q;

endmodule

// File: tb/tb_oam_dma.sv
// ---------------------------------------------------------------------------
// tb_oam_dma
//
// Drives page transfers into oam_dma with a RAM model (registered read port)
// and an OAM model. Expected behaviour comes from a cycle-offset model: in
// the cycle after edge E(k) of a transfer started at E0 the bench knows the
// expected busy/done, RAM address/select and OAM write from plain arithmetic
// on k, and checks final OAM contents against the RAM image.
// ---------------------------------------------------------------------------
module tb_oam_dma;

    logic clk;
    logic rst_n;

    oam_dma_if bus ();

    oam_dma #(.PAGE_BYTES(256)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] ram     [0:65535];
    logic [7:0] oam     [0:255];
    logic       oam_vld [0:255];
    logic       oam_clr;
    int         we_total;

    // RAM with a registered read port.
    always @(posedge clk) begin
        if (!bus.mem_cs_n && bus.mem_rw_n)
            bus.mem_data <= ram[bus.mem_addr];
    end

    // OAM write port plus a written-flag per entry and a write counter.
    always @(posedge clk) begin
        if (oam_clr) begin
            for (int i = 0; i < 256; i++) oam_vld[i] <= 1'b0;
        end else if (bus.oam_we) begin
            oam[bus.oam_addr]     <= bus.oam_wdata;
            oam_vld[bus.oam_addr] <= 1'b1;
            we_total              <= we_total + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic clear_oam();
        oam_clr = 1'b1;
        @(negedge clk);
        oam_clr = 1'b0;
    endtask

    // Per-cycle expectations for cycle k of a transfer (after edge E(k)).
    task automatic check_cycle(input int k, input logic [7:0] pg, input logic [7:0] oa);
        logic        exp_busy;
        logic        exp_cs;
        logic        exp_we;
        logic [15:0] exp_addr;
        int          n;
        exp_busy = (k <= 513);
        exp_cs   = (k >= 1) && (k <= 512);
        exp_addr = exp_cs ? {pg, 8'((k - 1) / 2)} : 16'h0000;
        exp_we   = (k >= 3) && (k <= 513) && (k % 2 == 1);
        check("busy",     32'(bus.busy),     32'(exp_busy));
        check("cpu_rdy",  32'(bus.cpu_rdy),  32'(!exp_busy));
        check("done",     32'(bus.done),     32'(k == 514));
        check("mem_rw_n", 32'(bus.mem_rw_n), 32'd1);
        check("mem_cs_n", 32'(bus.mem_cs_n), 32'(!exp_cs));
        check("mem_addr", 32'(bus.mem_addr), 32'(exp_addr));
        check("oam_we",   32'(bus.oam_we),   32'(exp_we));
        if (exp_we) begin
            n = (k - 3) / 2;
            check("oam_addr",  32'(bus.oam_addr),  32'(8'(oa + 8'(n))));
            check("oam_wdata", 32'(bus.oam_wdata), 32'(ram[{pg, 8'(n)}]));
        end
    endtask

    // Runs one transfer starting at the current negedge. Optional: a stray
    // start at cycle restart_k (must be ignored), a reset at cycle abort_k,
    // or a chained start in the done cycle (returns without idle checks).
    task automatic do_transfer(input logic [7:0] pg, input logic [7:0] oa,
                               input int restart_k, input logic [7:0] restart_pg,
                               input int abort_k,
                               input bit chain, input logic [7:0] chain_pg,
                               input logic [7:0] chain_oa);
        int we_base;
        int cnt;
        we_base       = we_total;
        bus.start     = 1'b1;
        bus.page      = pg;
        bus.oam_start = oa;
        for (int k = 0; k <= 514; k++) begin
            @(negedge clk);
            check_cycle(k, pg, oa);
            bus.start = 1'b0;
            if (k == abort_k) begin
                rst_n = 1'b0;
                #1;
                check("rst_busy",     32'(bus.busy),     32'd0);
                check("rst_cpu_rdy",  32'(bus.cpu_rdy),  32'd1);
                check("rst_mem_cs_n", 32'(bus.mem_cs_n), 32'd1);
                check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
                check("rst_oam_we",   32'(bus.oam_we),   32'd0);
                check("rst_oam_addr", 32'(bus.oam_addr), 32'd0);
                check("rst_done",     32'(bus.done),     32'd0);
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                // Bytes written strictly before the reset survive; the
                // pending write of the captured byte must not happen.
                cnt = (k >= 4) ? ((k - 4) / 2 + 1) : 0;
                for (int i = 0; i < 256; i++) begin
                    if (i < cnt) begin
                        check("abort_kept", 32'(oam[8'(oa + 8'(i))]), 32'(ram[{pg, 8'(i)}]));
                    end else begin
                        check("abort_unwritten", 32'(oam_vld[8'(oa + 8'(i))]), 32'd0);
                    end
                end
                check("abort_we_count", 32'(we_total - we_base), 32'(cnt));
                return;
            end
            if (k == restart_k) begin
                bus.start = 1'b1;
                bus.page  = restart_pg;
            end
            if (k == 514 && chain) begin
                bus.start     = 1'b1;
                bus.page      = chain_pg;
                bus.oam_start = chain_oa;
            end
        end
        if (chain) return;
        @(negedge clk);
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_done", 32'(bus.done), 32'd0);
        check("we_count",  32'(we_total - we_base), 32'd256);
        for (int i = 0; i < 256; i++)
            check("oam_data", 32'(oam[8'(oa + 8'(i))]), 32'(ram[{pg, 8'(i)}]));
    endtask

    initial begin
        int wb;
        logic [7:0] rp;
        logic [7:0] ro;
        oam_clr       = 1'b0;
        we_total      = 0;
        bus.start     = 1'b0;
        bus.page      = 8'h00;
        bus.oam_start = 8'h00;
        bus.mem_data  = 8'h00;
        for (int a = 0; a < 65536; a++) ram[a] = 8'($urandom);
        for (int i = 0; i < 256; i++) ram[16'h0200 + 16'(i)] = 8'(i) ^ 8'hA5;

        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("reset_busy",     32'(bus.busy),     32'd0);
        check("reset_cpu_rdy",  32'(bus.cpu_rdy),  32'd1);
        check("reset_done",     32'(bus.done),     32'd0);
        check("reset_oam_we",   32'(bus.oam_we),   32'd0);
        check("reset_oam_addr", 32'(bus.oam_addr), 32'd0);
        check("reset_oam_wd",   32'(bus.oam_wdata),32'd0);
        check("reset_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("reset_mem_cs_n", 32'(bus.mem_cs_n), 32'd1);
        check("reset_mem_rw_n", 32'(bus.mem_rw_n), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_oam();

        // Basic page 0x02 to OAM 0.
        do_transfer(8'h02, 8'h00, -1, 8'h00, -1, 1'b0, 8'h00, 8'h00);

        // OAM wrap.
        clear_oam();
        do_transfer(8'h07, 8'hF0, -1, 8'h00, -1, 1'b0, 8'h00, 8'h00);
        check("wrap_byte0",  32'(oam[8'hF0]), 32'(ram[16'h0700]));
        check("wrap_byte16", 32'(oam[8'h00]), 32'(ram[16'h0710]));

        // Stray start mid-transfer and in the LAST cycle are ignored.
        clear_oam();
        do_transfer(8'h02, 8'h00, 100, 8'h03, -1, 1'b0, 8'h00, 8'h00);
        clear_oam();
        do_transfer(8'h05, 8'h11, 513, 8'h03, -1, 1'b0, 8'h00, 8'h00);

        // Reset mid-transfer, with a capture pending, then a fresh transfer.
        clear_oam();
        do_transfer(8'h04, 8'h20, -1, 8'h00, 301, 1'b0, 8'h00, 8'h00);
        clear_oam();
        do_transfer(8'h02, 8'h33, -1, 8'h00, -1, 1'b0, 8'h00, 8'h00);

        // Start in the done cycle chains a second transfer.
        clear_oam();
        wb = we_total;
        do_transfer(8'h09, 8'h00, -1, 8'h00, -1, 1'b1, 8'h0A, 8'h80);
        do_transfer(8'h0A, 8'h80, -1, 8'h00, -1, 1'b0, 8'h00, 8'h00);
        check("chain_we_total", 32'(we_total - wb), 32'd512);

        // Randomized transfers with a random ignored start.
        for (int t = 0; t < 4; t++) begin
            rp = 8'($urandom);
            ro = 8'($urandom);
            clear_oam();
            do_transfer(rp, ro, int'($urandom_range(1, 513)), 8'($urandom), -1,
                        1'b0, 8'h00, 8'h00);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
